// File: rtl/uart_pkg.sv
// Shared UART feeder types: FSM state encoding and default baud constants.
package uart_pkg;

    // 100 MHz clock, 9600 baud
    localparam int CLKS_PER_BIT = 10417;
    // start + 8 data + stop
    localparam int FRAME_BITS   = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrapping pointers; full/empty come from the occupancy count.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed, the count gates what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds queued bytes to a UART transmitter, one start pulse per frame.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int FRAME_BITS   = uart_pkg::FRAME_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               tx_data,
    output logic                     transmit,
    output logic                     busy
);
    localparam int TW = $clog2((FRAME_BITS+1)*CLKS_PER_BIT);
    // Timer counts down to zero, so load with length-1.
    localparam logic [TW-1:0] START_LEN = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] WAIT_LEN  = TW'((FRAME_BITS+1)*CLKS_PER_BIT - 1);

    tx_state_e     state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          pop;
    logic [7:0]    head;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign transmit = (state == ST_START);
    assign busy     = (state != ST_IDLE);

    // State and bit-period timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next state, timer reload on each state entry, and the single pop point.
    always_comb begin
        state_nxt = state;
        timer_nxt = (timer != '0) ? timer - 1'b1 : timer;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_nxt = ST_LOAD;
                    timer_nxt = '0;
                end
            end
            ST_LOAD: begin
                pop       = 1'b1;
                state_nxt = ST_START;
                timer_nxt = START_LEN;
            end
            ST_START: begin
                if (timer == '0) begin
                    state_nxt = ST_WAIT;
                    timer_nxt = WAIT_LEN;
                end
            end
            ST_WAIT: begin
                // Frame remainder plus one guard bit before the next byte.
                if (timer == '0) begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Byte presented to the transmitter; held until the next LOAD.
    always_ff @(posedge clk) begin
        if (reset)    tx_data <= 8'h00;
        else if (pop) tx_data <= head;
    end

    // Sticky flag for a write dropped against a full FIFO with no pop.
    always_ff @(posedge clk) begin
        if (reset)                        overflow <= 1'b0;
        else if (wr_en && full && !pop)   overflow <= 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with short bit periods (4 clk/bit, 4-deep FIFO).
module tb_uart_tx_feeder;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FB    = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, transmit, busy;
    logic [2:0] count;
    logic [7:0] tx_data;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int c0;
    logic tx_prev = 1'b0;
    logic [7:0] pulse_data[$];
    int         pulse_cyc[$];

    uart_tx_feeder #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .transmit (transmit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log each transmit rising edge with the byte presented and its cycle.
    always @(negedge clk) begin
        if (transmit && !tx_prev) begin
            pulse_data.push_back(tx_data);
            pulse_cyc.push_back(cyc);
        end
        tx_prev <= transmit;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        pulse_data.delete();
        pulse_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset state
        tick(2);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_tx", transmit, 0);
        check("rst_busy", busy, 0);
        check("rst_txdata", tx_data, 8'h00);
        reset = 1'b0;
        tick(1);

        // Single byte: IDLE, LOAD, START x4, WAIT x44 -> busy falls at cycle 50
        clear_log();
        wr(8'hA5);
        check("single_count", count, 1);
        for (int n = 1; n <= 50; n++) begin
            tick(1);
            check($sformatf("single_tx_c%0d", n), transmit, (n >= 2 && n <= 5));
            check($sformatf("single_busy_c%0d", n), busy, (n <= 49));
            if (n == 2) check("single_txdata", tx_data, 8'hA5);
        end
        check("single_npulse", pulse_data.size(), 1);

        // Burst of three: pulses 50 cycles apart, in order
        clear_log();
        wr(8'h01);
        c0 = cyc;
        wr(8'h02);
        wr(8'h03);
        tick(160);
        check("burst_npulse", pulse_data.size(), 3);
        if (pulse_data.size() == 3) begin
            check("burst_lat", pulse_cyc[0] - c0, 2);
            check("burst_gap1", pulse_cyc[1] - pulse_cyc[0], 50);
            check("burst_gap2", pulse_cyc[2] - pulse_cyc[1], 50);
            check("burst_d0", pulse_data[0], 8'h01);
            check("burst_d1", pulse_data[1], 8'h02);
            check("burst_d2", pulse_data[2], 8'h03);
        end
        check("burst_count", count, 0);

        // Overflow: first byte goes in flight, then 5 writes against a 4-deep FIFO
        do_reset();
        clear_log();
        wr(8'h10);
        tick(2);
        for (int i = 0; i < 5; i++) wr(8'h11 + 8'(i));
        check("ovf_count", count, 4);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);
        tick(260);
        check("ovf_npulse", pulse_data.size(), 5);
        if (pulse_data.size() == 5)
            for (int i = 0; i < 5; i++)
                check($sformatf("ovf_d%0d", i), pulse_data[i], 8'h10 + 8'(i));
        check("ovf_drained", count, 0);
        check("ovf_sticky", overflow, 1);
        do_reset();
        check("ovf_cleared", overflow, 0);

        // Write on the LOAD cycle while full: the coinciding pop makes room
        clear_log();
        wr(8'h20);
        tick(2);
        for (int i = 0; i < 4; i++) wr(8'h21 + 8'(i));
        tick(45);
        check("ld_full", full, 1);
        check("ld_busy_idle", busy, 1);
        wr(8'h25);
        check("ld_count", count, 4);
        check("ld_ovf", overflow, 0);
        check("ld_tx", transmit, 1);
        check("ld_txdata", tx_data, 8'h21);
        tick(260);
        check("ld_npulse", pulse_data.size(), 6);
        if (pulse_data.size() == 6)
            for (int i = 0; i < 6; i++)
                check($sformatf("ld_d%0d", i), pulse_data[i], 8'h20 + 8'(i));

        // Reset during WAIT with two bytes queued
        do_reset();
        clear_log();
        wr(8'h30);
        wr(8'h31);
        wr(8'h32);
        tick(8);
        check("mid_queued", count, 2);
        check("mid_busy", busy, 1);
        check("mid_tx", transmit, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_tx", transmit, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_empty", empty, 1);
        clear_log();
        tick(100);
        check("mid_no_pulse", pulse_data.size(), 0);

        // Pointer wrap: 3 bytes, drain, 3 more
        clear_log();
        wr(8'd1);
        wr(8'd2);
        wr(8'd3);
        tick(160);
        wr(8'd4);
        wr(8'd5);
        wr(8'd6);
        tick(160);
        check("wrap_npulse", pulse_data.size(), 6);
        if (pulse_data.size() == 6)
            for (int i = 0; i < 6; i++)
                check($sformatf("wrap_d%0d", i), pulse_data[i], 8'(i + 1));
        check("wrap_empty", empty, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
